maptable_ckpt: RTL

Parametrised register alias table mapping architectural registers to ROB tags, with multiple branch checkpoints so several unresolved branches can be in flight at once. Sits between decode and dispatch: provides per-source tag/ready packets to the reservation stations, takes ROB writeback and commit updates, and on a mispredict restores the map to the snapshot taken at the offending branch. Each entry carries an explicit mapped bit, so ROB tag 0 is a legal tag.

---
 rtl/maptable_ckpt_pkg.sv | 60 ++++++
 rtl/maptable_ckpt_if.sv | 50 +++++
 rtl/maptable_ckpt_snapshot.sv | 44 ++++
 rtl/maptable_ckpt.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/maptable_ckpt_pkg.sv
// maptable_ckpt_pkg
// Shared types for the checkpointed register alias table: the per-port read
// packet, the stored map entry, checkpoint id type, default sizing, and the
// writeback/commit update rule used by both the live table and the snapshots.
// ROB tag width comes from the project-wide ROB_TAG_LEN define.

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

package maptable_ckpt_pkg;

    localparam int TAG_W              = `ROB_TAG_LEN;
    localparam int DEF_NUM_ARCH_REGS  = 32;
    localparam int DEF_NUM_CKPT       = 4;
    localparam int DEF_NUM_RD         = 2;
    localparam int REG_W              = $clog2(DEF_NUM_ARCH_REGS);
    localparam int CKPT_W             = $clog2(DEF_NUM_CKPT);

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [CKPT_W-1:0] CKPT_ID;

    // Architectural register 0 is hardwired and never renamed.
    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic mapped;
        logic ready;
        tag_t tag;
    } MAPTABLE_CKPT_PACKET;

    typedef struct packed {
        logic mapped;
        logic ready;
        tag_t tag;
    } MAP_ENTRY;

    // Canonical unmapped encoding: the value lives in the regfile, so it is ready.
    localparam MAP_ENTRY UNMAPPED_ENTRY = '{mapped: 1'b0, ready: 1'b1, tag: '0};

    // Writeback marks a matching in-flight mapping ready; commit of the matching
    // tag retires the mapping. Commit is applied after writeback so a same-cycle
    // pair on one tag ends unmapped.
    function automatic MAP_ENTRY entry_update(input MAP_ENTRY e,
                                              input logic     wb_hit,
                                              input tag_t     wb_tag,
                                              input logic     commit_hit,
                                              input tag_t     commit_tag);
        MAP_ENTRY r;
        r = e;
        if (wb_hit && r.mapped && (r.tag == wb_tag)) begin
            r.ready = 1'b1;
        end
        if (commit_hit && r.mapped && (r.tag == commit_tag)) begin
            r = UNMAPPED_ENTRY;
        end
        return r;
    endfunction

endpackage

// File: rtl/maptable_ckpt_if.sv
// maptable_ckpt_if
// Bundles every non-clock signal of the alias table.
//   master : decode / ROB / branch unit side (drives rename, reads, wb, commit,
//            checkpoint alloc/resolve/kill; receives rd_pkt, ckpt_id, ckpt_full)
//   slave  : the alias table itself

interface maptable_ckpt_if
    import maptable_ckpt_pkg::*;
#(
    parameter int NUM_ARCH_REGS = DEF_NUM_ARCH_REGS,
    parameter int NUM_CKPT      = DEF_NUM_CKPT,
    parameter int NUM_RD        = DEF_NUM_RD
);
    localparam int RW = $clog2(NUM_ARCH_REGS);
    localparam int CW = $clog2(NUM_CKPT);

    logic                                  rename_en;
    logic [RW-1:0]                         rename_rd;
    tag_t                                  rename_tag;
    logic [NUM_RD-1:0][RW-1:0]             rd_idx;
    MAPTABLE_CKPT_PACKET [NUM_RD-1:0]      rd_pkt;
    logic                                  wb_valid;
    logic [RW-1:0]                         wb_rd;
    tag_t                                  wb_tag;
    logic                                  commit_valid;
    logic [RW-1:0]                         commit_rd;
    tag_t                                  commit_tag;
    logic                                  ckpt_alloc;
    logic [CW-1:0]                         ckpt_id;
    logic                                  ckpt_full;
    logic                                  resolve_valid;
    logic [CW-1:0]                         resolve_id;
    logic                                  kill_valid;
    logic [CW-1:0]                         kill_id;

    modport master (
        output rename_en, rename_rd, rename_tag, rd_idx,
               wb_valid, wb_rd, wb_tag, commit_valid, commit_rd, commit_tag,
               ckpt_alloc, resolve_valid, resolve_id, kill_valid, kill_id,
        input  rd_pkt, ckpt_id, ckpt_full
    );

    modport slave (
        input  rename_en, rename_rd, rename_tag, rd_idx,
               wb_valid, wb_rd, wb_tag, commit_valid, commit_rd, commit_tag,
               ckpt_alloc, resolve_valid, resolve_id, kill_valid, kill_id,
        output rd_pkt, ckpt_id, ckpt_full
    );

endinterface

// File: rtl/maptable_ckpt_snapshot.sv
// maptable_snapshot
// One checkpoint slot: a full copy of the alias table taken at a branch.
// Ports: clock, reset_n (async active-low), load + load_data (capture the
// table), wb_* / commit_* (keep the copy in step with the ROB while the branch
// is unresolved), entries (current slot contents, used for a kill restore).

module maptable_snapshot
    import maptable_ckpt_pkg::*;
#(
    parameter int NUM_ARCH_REGS = DEF_NUM_ARCH_REGS
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 load,
    input  MAP_ENTRY [NUM_ARCH_REGS-1:0]         load_data,
    input  logic                                 wb_valid,
    input  logic [$clog2(NUM_ARCH_REGS)-1:0]     wb_rd,
    input  tag_t                                 wb_tag,
    input  logic                                 commit_valid,
    input  logic [$clog2(NUM_ARCH_REGS)-1:0]     commit_rd,
    input  tag_t                                 commit_tag,
    output MAP_ENTRY [NUM_ARCH_REGS-1:0]         entries
);
    localparam int RW = $clog2(NUM_ARCH_REGS);

    // Load data already includes this cycle's wb/commit, so a load replaces the
    // copy outright; otherwise the copy tracks wb/commit like the live table.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                entries[i] <= UNMAPPED_ENTRY;
            end
        end else if (load) begin
            entries <= load_data;
        end else begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                entries[i] <= entry_update(entries[i],
                                           wb_valid && (wb_rd == RW'(i)), wb_tag,
                                           commit_valid && (commit_rd == RW'(i)), commit_tag);
            end
        end
    end

endmodule

// File: rtl/maptable_ckpt.sv
// maptable_ckpt
// Register alias table (arch reg -> ROB tag) with NUM_CKPT branch checkpoints.
// Ports: clock, reset_n (async active-low), bus (maptable_ckpt_if.slave):
//   rename_en/rd/tag     rename one destination
//   rd_idx -> rd_pkt     combinational source lookups with wb bypass
//   wb_*, commit_*       ROB writeback / retirement updates
//   ckpt_alloc, ckpt_id, ckpt_full, resolve_*, kill_*  checkpoint management

module maptable_ckpt
    import maptable_ckpt_pkg::*;
#(
    parameter int NUM_ARCH_REGS = DEF_NUM_ARCH_REGS,
    parameter int NUM_CKPT      = DEF_NUM_CKPT,
    parameter int NUM_RD        = DEF_NUM_RD
) (
    input  logic          clock,
    input  logic          reset_n,
    maptable_ckpt_if.slave bus
);
    localparam int RW = $clog2(NUM_ARCH_REGS);
    localparam int CW = $clog2(NUM_CKPT);
    localparam logic [CW:0] FULL_COUNT = (CW+1)'(NUM_CKPT);

    MAP_ENTRY [NUM_ARCH_REGS-1:0] map_q;
    MAP_ENTRY [NUM_ARCH_REGS-1:0] map_d;
    MAP_ENTRY [NUM_ARCH_REGS-1:0] map_base;
    MAP_ENTRY [NUM_ARCH_REGS-1:0] snap_q [NUM_CKPT];

    logic [NUM_CKPT-1:0] live_q, live_d;
    logic [NUM_CKPT-1:0] resolved_q, resolved_d;
    logic [NUM_CKPT-1:0] snap_load;
    logic [CW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CW:0]         count_q, count_d;
    logic [CW:0]         keep_count;
    logic                kill_ok;
    logic                alloc_ok;
    logic                advance;

    // A kill only counts against a live slot; it blocks alloc and rename.
    assign kill_ok  = bus.kill_valid && live_q[bus.kill_id];
    assign alloc_ok = bus.ckpt_alloc && !kill_ok && (count_q != FULL_COUNT);

    assign bus.ckpt_id   = tail_q;
    assign bus.ckpt_full = (count_q == FULL_COUNT);

    // Next table: start from the snapshot on a kill, apply wb then commit, then
    // the rename last so a same-register commit of an older tag cannot clear it.
    always_comb begin
        map_base = kill_ok ? snap_q[bus.kill_id] : map_q;
        map_d    = map_base;
        for (int i = 0; i < NUM_ARCH_REGS; i++) begin
            map_d[i] = entry_update(map_base[i],
                                    bus.wb_valid && (bus.wb_rd == RW'(i)), bus.wb_tag,
                                    bus.commit_valid && (bus.commit_rd == RW'(i)), bus.commit_tag);
        end
        if (bus.rename_en && !kill_ok && (bus.rename_rd != ZERO_REG)) begin
            map_d[bus.rename_rd] = '{mapped: 1'b1, ready: 1'b0, tag: bus.rename_tag};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                map_q[i] <= UNMAPPED_ENTRY;
            end
        end else begin
            map_q <= map_d;
        end
    end

    // Source lookups read the registered table; a matching writeback this cycle
    // is bypassed into the ready bit regardless of which register it names.
    always_comb begin
        bus.rd_pkt = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (map_q[bus.rd_idx[p]].mapped) begin
                bus.rd_pkt[p].mapped = 1'b1;
                bus.rd_pkt[p].ready  = map_q[bus.rd_idx[p]].ready ||
                                       (bus.wb_valid && (bus.wb_tag == map_q[bus.rd_idx[p]].tag));
                bus.rd_pkt[p].tag    = map_q[bus.rd_idx[p]].tag;
            end else begin
                bus.rd_pkt[p] = '{mapped: 1'b0, ready: 1'b1, tag: '0};
            end
        end
    end

    // Snapshot slots capture the post-rename table at the tail on alloc.
    for (genvar g = 0; g < NUM_CKPT; g++) begin : g_snap
        assign snap_load[g] = alloc_ok && (tail_q == CW'(g));

        maptable_snapshot #(
            .NUM_ARCH_REGS (NUM_ARCH_REGS)
        ) u_snap (
            .clock        (clock),
            .reset_n      (reset_n),
            .load         (snap_load[g]),
            .load_data    (map_d),
            .wb_valid     (bus.wb_valid),
            .wb_rd        (bus.wb_rd),
            .wb_tag       (bus.wb_tag),
            .commit_valid (bus.commit_valid),
            .commit_rd    (bus.commit_rd),
            .commit_tag   (bus.commit_tag),
            .entries      (snap_q[g])
        );
    end

    // Checkpoint ring: kill truncates the ring at kill_id (slots are ordered by
    // distance from head), resolve marks a slot, head then retires the run of
    // resolved slots, and alloc appends at the tail. Occupancy is tracked with
    // an explicit count so full and empty differ even when head == tail.
    always_comb begin
        live_d     = live_q;
        resolved_d = resolved_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        keep_count = {1'b0, bus.kill_id - head_q};
        advance    = 1'b1;

        if (kill_ok) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                if ({1'b0, CW'(i) - head_q} >= keep_count) begin
                    live_d[i]     = 1'b0;
                    resolved_d[i] = 1'b0;
                end
            end
            tail_d  = bus.kill_id;
            count_d = keep_count;
        end

        if (bus.resolve_valid && live_d[bus.resolve_id]) begin
            resolved_d[bus.resolve_id] = 1'b1;
        end

        for (int i = 0; i < NUM_CKPT; i++) begin
            if (advance && live_d[head_d] && resolved_d[head_d]) begin
                live_d[head_d]     = 1'b0;
                resolved_d[head_d] = 1'b0;
                head_d             = head_d + 1'b1;
                count_d            = count_d - 1'b1;
            end else begin
                advance = 1'b0;
            end
        end

        if (alloc_ok) begin
            live_d[tail_q]     = 1'b1;
            resolved_d[tail_q] = 1'b0;
            tail_d             = tail_q + 1'b1;
            count_d            = count_d + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            live_q     <= '0;
            resolved_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            live_q     <= live_d;
            resolved_q <= resolved_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

endmodule
